mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares one external memory/MIO bus between the pipelined CPU's instruction-fetch port and its data-access (MEM stage) port. It serialises the two requesters onto the single bus, handles the bus's ready handshake, returns read data to the right requester and drives the pipeline-wide stall that freezes the PC and all pipeline registers while any access is outstanding.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory/MIO bus between the CPU's
// instruction-fetch port and its MEM-stage data port. One access is in
// flight at a time; read data is returned to the requester that owns it and
// a pipeline-wide stall is raised while any request is still outstanding.
// Optional bus-ready watchdog: define ARB_TIMEOUT_EN to build it in.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        if_elig;
  logic        dm_elig;
  logic        grant_if;
  logic        grant_dm;
  logic        finish;
  logic        abort;
  logic        timeout_hit;
  logic        prio_if;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_be;

  // A request whose completion pulse is showing this cycle is not eligible,
  // so a requester that has not yet dropped req is never granted twice.
  assign if_elig = if_req & ~if_valid;
  assign dm_elig = dm_req & ~dm_valid;

  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  // Bus registers are cleared whenever the arbiter returns to IDLE, so the
  // bus outputs read as zero there without extra gating.
  assign mem_req   = (state != IDLE);
  assign mem_we    = bus_we;
  assign mem_addr  = bus_addr;
  assign mem_wdata = bus_wdata;
  assign mem_be    = bus_be;

`ifdef ARB_TIMEOUT_EN
  localparam int raw_width   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int count_width = (raw_width < 8) ? 8 : ((raw_width > 16) ? 16 : raw_width);
  localparam logic [count_width-1:0] count_last = count_width'(TIMEOUT_CYCLES - 1);

  logic [count_width-1:0] wd_count;
  logic                   err_q;

  // Watchdog counts busy cycles without mem_ready, restarting on each grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
    end else if (grant_if || grant_dm) begin
      wd_count <= '0;
    end else if ((state != IDLE) && !mem_ready) begin
      wd_count <= wd_count + 1'b1;
    end
  end

  // Bus error stays set from the first abandoned access until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign timeout_hit = (state != IDLE) && (wd_count == count_last);
  assign bus_err     = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // State register; reset abandons whatever access is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for ready (or the watchdog) when busy.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && (!dm_elig || prio_if)) begin
          grant_if   = 1'b1;
          state_next = IF_BUSY;
        end else if (dm_elig) begin
          grant_dm   = 1'b1;
          state_next = DM_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the granted port onto the bus, return read data and
  // pulse the owner's valid on completion, and rotate fetch/data priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      prio_if   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (grant_if) begin
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_we    <= 1'b0;
        bus_be    <= 4'b1111;
      end else if (grant_dm) begin
        bus_addr  <= dm_addr;
        bus_wdata <= dm_we ? dm_wdata : 32'h0;
        bus_we    <= dm_we;
        bus_be    <= dm_we ? dm_be : 4'b1111;
      end else if (finish || abort) begin
        bus_addr  <= '0;
        bus_wdata <= '0;
        bus_we    <= 1'b0;
        bus_be    <= '0;
        if (state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= finish ? mem_rdata : 32'hDEAD_BEEF;
          prio_if  <= 1'b0;
        end else begin
          dm_valid <= 1'b1;
          if (!bus_we) begin
            dm_rdata <= finish ? mem_rdata : 32'hDEAD_BEEF;
          end
          if (if_req) begin
            prio_if <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written sequences for
// contention, reset during a busy cycle and (with ARB_TIMEOUT_EN) the watchdog.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        bus_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [3:0]  e_mem_be;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_dm_valid;
    logic [31:0] e_dm_rdata;
    logic        e_stall;
  } vec_t;

  localparam int NumVecs = 18;
  vec_t vecs [NumVecs];

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    dm_req    = v.dm_req;
    dm_we     = v.dm_we;
    dm_addr   = v.dm_addr;
    dm_wdata  = v.dm_wdata;
    dm_be     = v.dm_be;
    mem_ready = v.mem_ready;
    mem_rdata = v.mem_rdata;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, ".mem_req"},   mem_req,   v.e_mem_req);
    checkOutput({tag, ".mem_we"},    mem_we,    v.e_mem_we);
    checkOutput({tag, ".mem_addr"},  mem_addr,  v.e_mem_addr);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, v.e_mem_wdata);
    checkOutput({tag, ".mem_be"},    mem_be,    v.e_mem_be);
    checkOutput({tag, ".if_valid"},  if_valid,  v.e_if_valid);
    checkOutput({tag, ".if_rdata"},  if_rdata,  v.e_if_rdata);
    checkOutput({tag, ".dm_valid"},  dm_valid,  v.e_dm_valid);
    checkOutput({tag, ".dm_rdata"},  dm_rdata,  v.e_dm_rdata);
    checkOutput({tag, ".stall"},     stall,     v.e_stall);
  endtask

  initial begin
    logic [31:0] z;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    bit          saw_valid;
    z = 32'h0;

    // Each row: inputs for one cycle, outputs expected during that same cycle.
    vecs[0]  = '{1'b1, 1'b0, z, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, z, 1'b0, z, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, z, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, z, 1'b0, z, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, z, 1'b0, 1'b0, z, z, 4'h0, 1'b1, 32'h2008_0005,
                 1'b1, 1'b0, z, z, 4'hF, 1'b0, z, 1'b0, z, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, z, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b1, 32'h2008_0005, 1'b0, z, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, z, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h2008_0005, 1'b0, z, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h100, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h2008_0005, 1'b0, z, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h100, z, 4'h0, 1'b1, 32'h1111_2222,
                 1'b1, 1'b0, 32'h100, z, 4'hF, 1'b0, 32'h2008_0005, 1'b0, z, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h100, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h2008_0005, 1'b1, 32'h1111_2222, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h4, 1'b0, 1'b0, z, z, 4'h0, 1'b1, 32'h3333_4444,
                 1'b1, 1'b0, 32'h4, z, 4'hF, 1'b0, 32'h2008_0005, 1'b0, 32'h1111_2222, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h4, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b1, 32'h3333_4444, 1'b0, 32'h1111_2222, 1'b0};
    vecs[10] = '{1'b0, 1'b0, z, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h3333_4444, 1'b0, 32'h1111_2222, 1'b0};
    vecs[11] = '{1'b0, 1'b0, z, 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h3333_4444, 1'b0, 32'h1111_2222, 1'b1};
    for (int i = 12; i <= 14; i++) begin
      vecs[i] = '{1'b0, 1'b0, z, 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 1'b0, z,
                  1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 1'b0, 32'h3333_4444, 1'b0, 32'h1111_2222, 1'b1};
    end
    vecs[15] = '{1'b0, 1'b0, z, 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 1'b1, 32'h5555_6666,
                 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 1'b0, 32'h3333_4444, 1'b0, 32'h1111_2222, 1'b1};
    vecs[16] = '{1'b0, 1'b0, z, 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h3333_4444, 1'b1, 32'h1111_2222, 1'b0};
    vecs[17] = '{1'b0, 1'b0, z, 1'b0, 1'b0, z, z, 4'h0, 1'b0, z,
                 1'b0, 1'b0, z, z, 4'h0, 1'b0, 32'h3333_4444, 1'b0, 32'h1111_2222, 1'b0};

    // Bring the DUT out of its unknown power-up state.
    applyStimulus(vecs[0]);
    stepCycle();

    $display("[TB] vector table: reset, zero-wait fetch, contention, 3-wait store");
    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
      stepCycle();
    end

    // Continuous contention: both ports always requesting, bus always ready.
    $display("[TB] continuous contention, 8 accesses");
    ia        = 32'h1000;
    da        = 32'h2000;
    if_req    = 1'b1;
    if_addr   = ia;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = da;
    mem_ready = 1'b1;
    mem_rdata = 32'h0;
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      exp_addr = (k % 2 == 0) ? da : ia;
      exp_data = exp_addr ^ 32'hA5A5_A5A5;
      checkOutput($sformatf("cont%0d.mem_req", k), mem_req, 1'b1);
      checkOutput($sformatf("cont%0d.grant_addr", k), mem_addr, exp_addr);
      mem_rdata = exp_data;
      stepCycle();
      checkOutput($sformatf("cont%0d.mem_req_idle", k), mem_req, 1'b0);
      if (k % 2 == 0) begin
        checkOutput($sformatf("cont%0d.dm_valid", k), dm_valid, 1'b1);
        checkOutput($sformatf("cont%0d.if_valid", k), if_valid, 1'b0);
        checkOutput($sformatf("cont%0d.dm_rdata", k), dm_rdata, exp_data);
        da      = da + 32'h4;
        dm_addr = da;
      end else begin
        checkOutput($sformatf("cont%0d.if_valid", k), if_valid, 1'b1);
        checkOutput($sformatf("cont%0d.dm_valid", k), dm_valid, 1'b0);
        checkOutput($sformatf("cont%0d.if_rdata", k), if_rdata, exp_data);
        ia      = ia + 32'h4;
        if_addr = ia;
      end
      if (k == 7) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end

    // mem_ready while IDLE must not start or complete anything.
    $display("[TB] mem_ready while idle, then reset during DM_BUSY");
    stepCycle();
    checkOutput("idle_ready.mem_req", mem_req, 1'b0);
    checkOutput("idle_ready.if_valid", if_valid, 1'b0);
    checkOutput("idle_ready.dm_valid", dm_valid, 1'b0);

    // Reset coinciding with mem_ready in DM_BUSY: reset wins, no valid pulse.
    mem_ready = 1'b0;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h300;
    stepCycle();
    stepCycle();
    checkOutput("rst_busy.mem_req", mem_req, 1'b1);
    checkOutput("rst_busy.mem_addr", mem_addr, 32'h300);
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0077;
    stepCycle();
    reset     = 1'b0;
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("rst_busy.dm_valid", dm_valid, 1'b0);
    checkOutput("rst_busy.mem_req_after", mem_req, 1'b0);
    checkOutput("rst_busy.mem_addr_after", mem_addr, 32'h0);
    checkOutput("rst_busy.mem_be_after", mem_be, 4'h0);
    checkOutput("rst_busy.if_rdata", if_rdata, 32'h0);
    checkOutput("rst_busy.dm_rdata", dm_rdata, 32'h0);
    checkOutput("rst_busy.stall", stall, 1'b0);
    stepCycle();
    checkOutput("rst_busy.no_late_valid", dm_valid, 1'b0);
    checkOutput("rst_busy.still_idle", mem_req, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: the bus never answers, so the fetch is abandoned.
    $display("[TB] watchdog timeout with TIMEOUT_CYCLES=4");
    if_req    = 1'b1;
    if_addr   = 32'h40;
    mem_ready = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 30 && !saw_valid; c++) begin
      stepCycle();
      if (if_valid) saw_valid = 1'b1;
    end
    checkOutput("timeout.if_valid_seen", saw_valid, 1'b1);
    checkOutput("timeout.if_rdata", if_rdata, 32'hDEAD_BEEF);
    checkOutput("timeout.bus_err", bus_err, 1'b1);
    if_req = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("timeout.bus_err_sticky", bus_err, 1'b1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("timeout.bus_err_reset", bus_err, 1'b0);
`else
    saw_valid = 1'b0;
    checkOutput("bus_err_tied", bus_err, 1'b0);
    checkOutput("no_valid_flag", saw_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
